// File: rtl/line_feeder.sv
// line_feeder: MSB-first serial-to-parallel line assembler feeding a show-ahead FIFO; optional pop counter via LINE_FEEDER_COUNT_EN.
// Latency: last bit at edge N, pushed at edge N+1, line visible in cycle N+2. Backpressure: bitReady low while a finished word waits to push.
module line_feeder #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     bitIn,
  input  logic                     bitValid,
  output logic                     bitReady,
  input  logic                     readLine,
  output logic [WIDTH-1:0]         line,
  output logic                     lineValid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              lineCnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] LASTBIT = BW'(WIDTH - 1);
  localparam logic [AW:0]   FULLCNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PUSH  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [BW-1:0]    bitcnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      cnt;
  logic             take, push, pop;

  assign lineValid = (cnt != '0);
  assign full      = (cnt == FULLCNT);
  assign count     = cnt;
  assign pop       = readLine && lineValid;
  assign line      = lineValid ? mem[rptr] : '0;

  always_comb begin
    state_nxt = state;
    bitReady  = 1'b1;
    take      = 1'b0;
    push      = 1'b0;
    case (state)
      IDLE, SHIFT: begin
        take = bitValid;
        if (take) state_nxt = (bitcnt == LASTBIT) ? PUSH : SHIFT;
      end
      PUSH: begin
        bitReady = 1'b0;
        // a pop at the same edge frees the slot this push needs
        push = !full || pop;
        if (push) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      bitcnt <= '0;
      shreg  <= '0;
      wptr   <= '0;
      rptr   <= '0;
      cnt    <= '0;
    end else begin
      state <= state_nxt;
      if (take) begin
        shreg  <= {shreg[WIDTH-2:0], bitIn};
        bitcnt <= bitcnt + BW'(1);
      end
      if (push) begin
        bitcnt <= '0;
        wptr   <= wptr + AW'(1);
      end
      if (pop) rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + (AW + 1)'(1);
        2'b01:   cnt <= cnt - (AW + 1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push) mem[wptr] <= shreg;
  end

`ifdef LINE_FEEDER_COUNT_EN
  logic [15:0] lcnt;
  always_ff @(posedge clk) begin
    if (!rst)     lcnt <= 16'h0000;
    else if (pop) lcnt <= lcnt + 16'd1;
  end
  assign lineCnt = lcnt;
`else
  assign lineCnt = 16'h0000;
`endif

endmodule

// File: tb/tb_line_feeder.sv
// Bench for line_feeder: queue-level reference model checked every cycle plus directed literal checks.
module tb_line_feeder;
  localparam int WIDTH = 25;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        bitIn = 1'b0;
  logic        bitValid = 1'b0;
  logic        bitReady;
  logic        readLine = 1'b0;
  logic [24:0] line;
  logic        lineValid;
  logic        full;
  logic [2:0]  count;
  logic [15:0] lineCnt;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  line_feeder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bitIn(bitIn), .bitValid(bitValid), .bitReady(bitReady),
    .readLine(readLine), .line(line), .lineValid(lineValid), .full(full),
    .count(count), .lineCnt(lineCnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a partially assembled word plus a queue of complete lines.
  logic [24:0] mq[$];
  logic [24:0] m_acc = '0;
  int          m_nb = 0;
  bit          m_pend = 1'b0;
  logic [15:0] m_lcnt = '0;

  always @(posedge clk) begin
    bit do_pop;
    if (!rst) begin
      mq.delete();
      m_acc = '0; m_nb = 0; m_pend = 1'b0; m_lcnt = '0;
    end else begin
      do_pop = readLine && (mq.size() > 0);
      if (do_pop) begin
        void'(mq.pop_front());
        m_lcnt = m_lcnt + 16'd1;
      end
      if (m_pend) begin
        if (mq.size() < DEPTH) begin
          mq.push_back(m_acc);
          m_pend = 1'b0;
          m_nb = 0;
        end
      end else if (bitValid) begin
        m_acc = {m_acc[23:0], bitIn};
        m_nb++;
        if (m_nb == WIDTH) m_pend = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_line",      32'(line),      (mq.size() > 0) ? 32'(mq[0]) : 32'h0);
      check("m_lineValid", 32'(lineValid), 32'(mq.size() > 0));
      check("m_full",      32'(full),      32'(mq.size() == DEPTH));
      check("m_count",     32'(count),     32'(mq.size()));
      check("m_bitReady",  32'(bitReady),  32'(!m_pend));
`ifdef LINE_FEEDER_COUNT_EN
      check("m_lineCnt",   32'(lineCnt),   32'(m_lcnt));
`else
      check("m_lineCnt",   32'(lineCnt),   32'h0);
`endif
    end
  end

  task automatic send_line(input logic [24:0] w, input int nbits, input bit gap);
    int guard;
    for (int i = 0; i < nbits; i++) begin
      if (gap) begin
        @(negedge clk);
        bitValid = 1'b0;
      end
      @(negedge clk);
      bitValid = 1'b1;
      bitIn = w[24-i];
      guard = 0;
      while (!bitReady && guard < 64) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 64) check("bitReady_timeout", 32'(bitReady), 32'h1);
    end
  endtask

  task automatic pop_one();
    @(negedge clk);
    readLine = 1'b1;
    @(negedge clk);
    readLine = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bitValid = 1'b0;
    readLine = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b1;
    chk_en = 1'b1;
    check("rst_count",    32'(count),     32'h0);
    check("rst_line",     32'(line),      32'h0);
    check("rst_bitReady", 32'(bitReady),  32'h1);
    check("rst_full",     32'(full),      32'h0);
    check("rst_lineCnt",  32'(lineCnt),   32'h0);

    // Single line, continuous valid
    send_line(25'h1555555, 25, 1'b0);
    @(negedge clk);
    bitValid = 1'b0;
    check("lat_bitReady", 32'(bitReady), 32'h0);
    @(negedge clk);
    check("lat_lineValid", 32'(lineValid), 32'h1);
    check("lat_line",      32'(line),      32'h1555555);
    check("lat_count",     32'(count),     32'h1);
    pop_one();
    check("pop1_count", 32'(count), 32'h0);
    check("pop1_line",  32'(line),  32'h0);

    // Fill FIFO, park a fifth line, release with a single pop
    for (int k = 1; k <= 5; k++) send_line(25'(k), 25, 1'b0);
    @(negedge clk);
    bitValid = 1'b0;
    repeat (3) @(negedge clk);
    check("park_full",     32'(full),     32'h1);
    check("park_bitReady", 32'(bitReady), 32'h0);
    check("park_line",     32'(line),     32'h1);
    pop_one();
    check("rel_count",    32'(count),    32'h4);
    check("rel_line",     32'(line),     32'h2);
    check("rel_bitReady", 32'(bitReady), 32'h1);
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      check("drain_line", 32'(line), 32'(k));
      readLine = 1'b1;
    end
    @(negedge clk);
    readLine = 1'b0;
    check("drain_count", 32'(count), 32'h0);

    // readLine while empty is ignored
    readLine = 1'b1;
    repeat (5) @(negedge clk);
    readLine = 1'b0;
    check("empty_count", 32'(count), 32'h0);
    check("empty_line",  32'(line),  32'h0);
`ifdef LINE_FEEDER_COUNT_EN
    check("empty_lineCnt", 32'(lineCnt), 32'd6);
`else
    check("empty_lineCnt", 32'(lineCnt), 32'd0);
`endif

    // Reset mid-line with two lines queued
    send_line(25'h0000011, 25, 1'b0);
    send_line(25'h0000022, 25, 1'b0);
    send_line(25'h0F0F0F0, 12, 1'b0);
    @(negedge clk);
    check("pre_rst_count", 32'(count), 32'h2);
    bitValid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("midrst_count",     32'(count),     32'h0);
    check("midrst_lineValid", 32'(lineValid), 32'h0);
    send_line(25'h1FFFFFF, 25, 1'b0);
    @(negedge clk);
    bitValid = 1'b0;
    @(negedge clk);
    check("postrst_count", 32'(count), 32'h1);
    check("postrst_line",  32'(line),  32'h1FFFFFF);
    pop_one();

    // Gapped valid
    send_line(25'h0ABCDEF, 25, 1'b1);
    @(negedge clk);
    bitValid = 1'b0;
    @(negedge clk);
    check("gap_line",  32'(line),  32'h0ABCDEF);
    check("gap_count", 32'(count), 32'h1);
    pop_one();

    // Pop counter over three push/pop pairs from reset
    do_reset();
    for (int k = 0; k < 3; k++) begin
      send_line(25'(32'h100 + k), 25, 1'b0);
      @(negedge clk);
      bitValid = 1'b0;
      @(negedge clk);
      pop_one();
    end
    @(negedge clk);
`ifdef LINE_FEEDER_COUNT_EN
    check("pairs_lineCnt", 32'(lineCnt), 32'd3);
`else
    check("pairs_lineCnt", 32'(lineCnt), 32'd0);
`endif

    @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
